// File: rtl/bit_popcount_pkg.sv
// Shared widths and output-buffer state encoding for the popcount frame accumulator.
package bit_popcount_pkg;

    // Occupancy of the 2-entry output buffer
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    // Width of a popcount of a WIDTH-bit word (0..WIDTH inclusive)
    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

    // Width of a frame sum; covers FRAME_LEN*WIDTH without wrap
    function automatic int unsigned sum_w(input int unsigned width, input int unsigned frame_len);
        return cnt_w(width) + $clog2(frame_len);
    endfunction

    // Beat counter width; at least one bit even for single-beat frames
    function automatic int unsigned beat_w(input int unsigned frame_len);
        return (frame_len > 1) ? $clog2(frame_len) : 1;
    endfunction

endpackage

// File: rtl/popcount_out_buf.sv
// Two-entry output buffer (EMPTY/ONE/FULL) with valid/ready pop and sticky drop flag.
// data_o always presents the oldest entry; a push into a full buffer without a pop is dropped.
module popcount_out_buf
    import bit_popcount_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic          clk_i,
    input  logic          srst_n_i,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_ready_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    output logic          ovf_o
);

    buf_state_e    state_q, state_d;
    logic [DW-1:0] e0_q, e0_d;
    logic [DW-1:0] e1_q, e1_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic          pop_c;

    assign pop_c = valid_q & pop_ready_i;

    // Next-state logic: e0 is the head, e1 the second-oldest entry
    always_comb begin
        state_d = state_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        ovf_d   = ovf_q;
        case (state_q)
            BUF_EMPTY: begin
                if (push_i) begin
                    e0_d    = push_data_i;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (push_i && pop_c) begin
                    e0_d = push_data_i;
                end else if (push_i) begin
                    e1_d    = push_data_i;
                    state_d = BUF_FULL;
                end else if (pop_c) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (pop_c) begin
                    e0_d = e1_q;
                    if (push_i) begin
                        e1_d = push_data_i;
                    end else begin
                        state_d = BUF_ONE;
                    end
                end else if (push_i) begin
                    ovf_d = 1'b1;
                end
            end
            default: begin
                state_d = BUF_EMPTY;
            end
        endcase
        valid_d = (state_d != BUF_EMPTY);
    end

    // State and storage registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_q <= BUF_EMPTY;
            e0_q    <= '0;
            e1_q    <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_o  = e0_q;
    assign valid_o = valid_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/bit_popcount_frame_acc.sv
// Sums FRAME_LEN valid popcount beats into one frame result and queues it in a 2-entry buffer.
// Optional feature macro: POPCNT_ACC_THRESH_EN adds thresh_i/above_o and a per-entry
// above-threshold flag sampled on the push cycle.
module bit_popcount_frame_acc
    import bit_popcount_pkg::*;
#(
    parameter  int unsigned WIDTH     = 24,
    parameter  int unsigned FRAME_LEN = 8,
    localparam int unsigned CNT_W     = cnt_w(WIDTH),
    localparam int unsigned SUM_W     = sum_w(WIDTH, FRAME_LEN)
) (
    input  logic             clk_i,
    input  logic             srst_n_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             cnt_val_i,
`ifdef POPCNT_ACC_THRESH_EN
    input  logic [SUM_W-1:0] thresh_i,
    output logic             above_o,
`endif
    output logic [SUM_W-1:0] sum_o,
    output logic             sum_val_o,
    input  logic             sum_ready_i,
    output logic             ovf_o
);

    localparam int unsigned     BEAT_W    = beat_w(FRAME_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);
`ifdef POPCNT_ACC_THRESH_EN
    localparam int unsigned ENT_W = SUM_W + 1;
`else
    localparam int unsigned ENT_W = SUM_W;
`endif

    logic [SUM_W-1:0]  acc_q, acc_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [SUM_W-1:0]  result_c;
    logic              push_c;
    logic [ENT_W-1:0]  push_data_c;
    logic [ENT_W-1:0]  head_data;

    // Accumulate valid beats; the final beat of a frame emits acc+cnt and restarts the frame
    always_comb begin
        acc_d    = acc_q;
        beat_d   = beat_q;
        push_c   = 1'b0;
        result_c = acc_q + SUM_W'(cnt_i);
        if (cnt_val_i) begin
            if (beat_q == LAST_BEAT) begin
                push_c = 1'b1;
                acc_d  = '0;
                beat_d = '0;
            end else begin
                acc_d  = result_c;
                beat_d = beat_q + BEAT_W'(1);
            end
        end
    end

    // Accumulator and beat counter; reset discards any partial frame
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            acc_q  <= '0;
            beat_q <= '0;
        end else begin
            acc_q  <= acc_d;
            beat_q <= beat_d;
        end
    end

`ifdef POPCNT_ACC_THRESH_EN
    assign push_data_c = {(result_c >= thresh_i), result_c};
`else
    assign push_data_c = result_c;
`endif

    popcount_out_buf #(
        .DW (ENT_W)
    ) u_out_buf (
        .clk_i       (clk_i),
        .srst_n_i    (srst_n_i),
        .push_i      (push_c),
        .push_data_i (push_data_c),
        .pop_ready_i (sum_ready_i),
        .data_o      (head_data),
        .valid_o     (sum_val_o),
        .ovf_o       (ovf_o)
    );

    assign sum_o = head_data[SUM_W-1:0];
`ifdef POPCNT_ACC_THRESH_EN
    assign above_o = head_data[SUM_W];
`endif

endmodule
